// File: rtl/adc_cap_sequencer.sv
// Capture sequencer: fires ADC buffer capture requests under a channel mask, one channel at a time
// or all together, and checks each buffer starts and finishes within bounded times.
module adc_cap_sequencer #(
    parameter int unsigned NCHAN         = 4,
    parameter int unsigned CAP_HOLD      = 4,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned DONE_TIMEOUT  = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode_i,
    input  logic [NCHAN-1:0] chan_mask_i,
    input  logic [NCHAN-1:0] done_i,
    output logic [NCHAN-1:0] capture_o,
    output logic             busy_o,
    output logic             complete_o,
    output logic             error_o,
    output logic [3:0]       err_chan_o,
    output logic [3:0]       cur_chan_o
);

    localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);
    localparam int unsigned HW = $clog2(CAP_HOLD + 1);

    localparam logic [TW-1:0] StartLim = TW'(START_TIMEOUT);
    localparam logic [TW-1:0] DoneLim  = TW'(DONE_TIMEOUT);
    localparam logic [HW-1:0] HoldLast = HW'(CAP_HOLD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitStart,
        StWaitDone,
        StNext,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [NCHAN-1:0] mask_q, mask_d;
    logic [NCHAN-1:0] active_q, active_d;
    logic             mode_q, mode_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       cur_q, cur_d;
    logic             error_q, error_d;
    logic [3:0]       err_chan_q, err_chan_d;
    logic [NCHAN-1:0] capture_q;
    logic             busy_q;
    logic             complete_q;
    logic [NCHAN-1:0] remain;

    function automatic logic [3:0] low_idx(input logic [NCHAN-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [NCHAN-1:0] low_onehot(input logic [NCHAN-1:0] v);
        logic [NCHAN-1:0] oh;
        logic             found;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            if (v[i] && !found) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        active_d   = active_q;
        mode_d     = mode_q;
        hold_d     = hold_q;
        timer_d    = (timer_q == DoneLim) ? timer_q : timer_q + TW'(1);
        cur_d      = cur_q;
        error_d    = error_q;
        err_chan_d = err_chan_q;
        remain     = mask_q & ~active_q;

        if (abort_i) begin
            // Abort also swallows a start arriving in the same IDLE cycle.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mask_d     = chan_mask_i;
                        mode_d     = mode_i;
                        error_d    = 1'b0;
                        err_chan_d = 4'd0;
                        hold_d     = '0;
                        if (chan_mask_i == '0) begin
                            // Empty run passes through NEXT, which finds nothing left.
                            active_d = '0;
                            cur_d    = 4'd0;
                            state_d  = StNext;
                        end else if (mode_i) begin
                            active_d = chan_mask_i;
                            cur_d    = 4'd0;
                            state_d  = StArm;
                        end else begin
                            active_d = low_onehot(chan_mask_i);
                            cur_d    = low_idx(chan_mask_i);
                            state_d  = StArm;
                        end
                    end
                end
                StArm: begin
                    if (hold_q == HoldLast) begin
                        timer_d = '0;
                        state_d = StWaitStart;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                StWaitStart: begin
                    if ((active_q & done_i) == '0) begin
                        timer_d = '0;
                        state_d = StWaitDone;
                    end else if (timer_q >= StartLim) begin
                        error_d    = 1'b1;
                        err_chan_d = low_idx(active_q & done_i);
                        state_d    = StNext;
                    end
                end
                StWaitDone: begin
                    if ((active_q & ~done_i) == '0) begin
                        state_d = StNext;
                    end else if (timer_q >= DoneLim) begin
                        error_d    = 1'b1;
                        err_chan_d = low_idx(active_q & ~done_i);
                        state_d    = StNext;
                    end
                end
                StNext: begin
                    // A timeout lands here too, so the remaining channels are skipped.
                    if (error_q || mode_q || (remain == '0)) begin
                        state_d = StFinish;
                    end else begin
                        mask_d   = remain;
                        active_d = low_onehot(remain);
                        cur_d    = low_idx(remain);
                        hold_d   = '0;
                        state_d  = StArm;
                    end
                end
                StFinish: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            active_q   <= '0;
            mode_q     <= 1'b0;
            hold_q     <= '0;
            timer_q    <= '0;
            cur_q      <= 4'd0;
            error_q    <= 1'b0;
            err_chan_q <= 4'd0;
            capture_q  <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            active_q   <= active_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            timer_q    <= timer_d;
            cur_q      <= cur_d;
            error_q    <= error_d;
            err_chan_q <= err_chan_d;
            capture_q  <= (state_d == StArm) ? active_d : '0;
            busy_q     <= (state_d != StIdle);
            complete_q <= (state_d == StFinish);
        end
    end

    assign capture_o  = capture_q;
    assign busy_o     = busy_q;
    assign complete_o = complete_q;
    assign error_o    = error_q;
    assign err_chan_o = err_chan_q;
    assign cur_chan_o = cur_q;

endmodule
